// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes,
// iteration-mode select and operand helpers.
package muldiv_ctrl_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  function automatic logic is_handled(input logic [5:0] f);
    return f inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                     FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction

  // 0x80000000 maps onto itself, which read as unsigned is the wanted 2^31.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration retiring BITS product/quotient bits: shift-add
// multiply or restoring divide, chained BITS times within a single cycle.
module muldiv_step
  import muldiv_ctrl_pkg::*;
#(
  parameter int BITS = 1
) (
  input  step_mode_e  mode,
  input  logic [31:0] opd,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  // {hi,lo} holds partial product over the shifting multiplier.
  function automatic logic [63:0] mul_bit(input logic [63:0] v, input logic [31:0] m);
    logic [32:0] sum;
    sum = {1'b0, v[63:32]} + {1'b0, (v[0] ? m : 32'd0)};
    return {sum, v[31:1]};
  endfunction

  // {hi,lo} holds partial remainder over the dividend/quotient shift register.
  function automatic logic [63:0] div_bit(input logic [63:0] v, input logic [31:0] d);
    logic [32:0] sh;
    logic [31:0] diff;
    logic        ge;
    sh   = {v[63:32], v[31]};
    ge   = (sh >= {1'b0, d});
    diff = sh[31:0] - d;
    return ge ? {diff, v[30:0], 1'b1} : {sh[31:0], v[30:0], 1'b0};
  endfunction

  for (genvar g = 0; g < BITS; g++) begin : g_bit
    logic [63:0] cur;
    logic [63:0] nxt;
    if (g == 0) begin : g_first
      assign cur = {hi_in, lo_in};
    end else begin : g_rest
      assign cur = g_bit[g-1].nxt;
    end
    assign nxt = (mode == STEP_DIV) ? div_bit(cur, opd) : mul_bit(cur, opd);
  end

  assign {hi_out, lo_out} = g_bit[BITS-1].nxt;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the execute stage: iterative MULT/MULTU/DIV/DIVU plus
// MFHI/MFLO/MTHI/MTLO, with a stall interlock while a sequence is in flight.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [5:0]  funct,
  input  logic [31:0] rrs,
  input  logic [31:0] rrt,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rslt,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int ITERS = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic [31:0] acc_hi, acc_lo, opd, rrs_lat;
  logic        op_div, neg_q, neg_r, div_zero;
  logic [31:0] step_hi, step_lo;

  logic is_mul, is_div, is_signed, accept;

  assign is_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign is_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign accept    = req_valid && (state_q == S_IDLE) && (is_mul || is_div);

  assign busy  = (state_q != S_IDLE);
  assign stall = req_valid && busy && is_handled(funct);
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    rslt = 32'd0;
    if (req_valid && !stall) begin
      if (funct == FUNCT_MFHI)      rslt = hi_q;
      else if (funct == FUNCT_MFLO) rslt = lo_q;
    end
  end

  muldiv_step #(.BITS(BITS_PER_CYCLE)) u_step (
    .mode   (op_div ? STEP_DIV : STEP_MUL),
    .opd    (opd),
    .hi_in  (acc_hi),
    .lo_in  (acc_lo),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  // Sign fix-up applied in FIX on the unsigned magnitude results
  logic signed [63:0] prod_s, prod_fix;
  logic signed [31:0] quo_s, rem_s, quo_fix, rem_fix;

  assign prod_s   = $signed({acc_hi, acc_lo});
  assign prod_fix = neg_q ? -prod_s : prod_s;
  assign quo_s    = $signed(acc_lo);
  assign rem_s    = $signed(acc_hi);
  assign quo_fix  = neg_q ? -quo_s : quo_s;
  assign rem_fix  = neg_r ? -rem_s : rem_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && funct == FUNCT_MTHI) hi_d = rrs;
        if (req_valid && funct == FUNCT_MTLO) lo_d = rrs;
        if (accept) begin
          cnt_d   = '0;
          state_d = is_div ? S_DIV : S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!op_div) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div_zero) begin
          hi_d = rrs_lat;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand/accumulator path: only meaningful while busy, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_hi   <= 32'd0;
      acc_lo   <= magnitude(rrs, is_signed);
      opd      <= magnitude(rrt, is_signed);
      rrs_lat  <= rrs;
      op_div   <= is_div;
      neg_q    <= is_signed && (rrs[31] ^ rrt[31]);
      neg_r    <= is_signed && rrs[31];
      div_zero <= (rrt == 32'd0);
    end else if (state_q == S_MUL || state_q == S_DIV) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: one instance at 1 bit/cycle, one at 4,
// both fed the same instruction stream and checked against an arithmetic model.
module tb_muldiv_ctrl;

  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] rrs = 32'd0, rrt = 32'd0;

  logic        stall1, busy1, stall4, busy4;
  logic [31:0] rslt1, hi1, lo1, rslt4, hi4, lo4;

  muldiv_ctrl #(.BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .funct(funct), .rrs(rrs), .rrt(rrt),
    .stall(stall1), .busy(busy1), .rslt(rslt1), .hi(hi1), .lo(lo1)
  );

  muldiv_ctrl #(.BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .funct(funct), .rrs(rrs), .rrt(rrt),
    .stall(stall4), .busy(busy4), .rslt(rslt4), .hi(hi4), .lo(lo4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Architectural model: HI/LO in program order plus last busy cycle per unit
  logic [31:0] mhi = 32'd0, mlo = 32'd0;
  int busy1_end = -1000;
  int busy4_end = -1000;
  logic [31:0] exp_q[$];

  function automatic bit tb_handled(input logic [5:0] f);
    return (f >= 6'h10 && f <= 6'h13) || (f >= 6'h18 && f <= 6'h1B);
  endfunction

  function automatic bit has_rslt(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MFLO) || !tb_handled(f);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  task automatic model_exec(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            input int rc);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    longint             sa, sb;
    case (f)
      F_MTHI: mhi = a;
      F_MTLO: mlo = a;
      F_MULT: begin
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {mhi, mlo} = ps;
      end
      F_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        {mhi, mlo} = pu;
      end
      F_DIV, F_DIVU: begin
        if (b == 32'd0) begin
          mlo = 32'hFFFF_FFFF;
          mhi = a;
        end else if (f == F_DIV) begin
          sa  = longint'($signed(a));
          sb  = longint'($signed(b));
          mlo = 32'(sa / sb);
          mhi = 32'(sa % sb);
        end else begin
          mlo = a / b;
          mhi = a % b;
        end
      end
      default: ;
    endcase
    if (f inside {F_MULT, F_MULTU, F_DIV, F_DIVU}) begin
      busy1_end = rc + 33;
      busy4_end = rc + 9;
    end
  endtask

  task automatic check_ctrl();
    bit hv;
    hv = req_valid && tb_handled(funct);
    chk("busy1", 32'(busy1), 32'(cyc <= busy1_end));
    chk("busy4", 32'(busy4), 32'(cyc <= busy4_end));
    chk("stall1", 32'(stall1), 32'(hv && cyc <= busy1_end));
    chk("stall4", 32'(stall4), 32'(hv && cyc <= busy4_end));
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int  n;
    int  rc;
    bit  done;
    req_valid = 1'b1;
    funct     = f;
    rrs       = a;
    rrt       = b;
    if (has_rslt(f))
      exp_q.push_back(f == F_MFHI ? mhi : (f == F_MFLO ? mlo : 32'd0));
    done = 1'b0;
    n    = 0;
    rc   = cyc;
    while (!done) begin
      @(negedge clk);
      check_ctrl();
      rc = cyc;
      if (!stall1 && !stall4) begin
        done = 1'b1;
      end else if (++n > 100) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout funct %h: got stall %b/%b want release", f, stall1, stall4);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    model_exec(f, a, b, rc);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check_ctrl();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_regs(input string name, input logic [31:0] eh, input logic [31:0] el);
    chk({name, "_hi1"}, hi1, eh);
    chk({name, "_lo1"}, lo1, el);
    chk({name, "_hi4"}, hi4, eh);
    chk({name, "_lo4"}, lo4, el);
  endtask

  // Monitor: compare read data whenever an instruction retires on both units
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst && req_valid && !stall1 && !stall4 && has_rslt(funct)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rslt_unexpected funct %h: got %h want no output", funct, rslt1);
      end else begin
        e = exp_q.pop_front();
        chk("rslt1", rslt1, e);
        chk("rslt4", rslt4, e);
      end
    end
  end

  logic [31:0] edge_v[6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'h7FFF_FFFF};
  logic [5:0]  ops[9]    = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO, 6'h20};

  function automatic logic [31:0] pick();
    return ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom();
  endfunction

  initial begin
    logic [5:0] f;
    #12;
    chk("reset_busy", 32'(busy1), 32'd0);
    chk("reset_stall", 32'(stall4), 32'd0);
    chk("reset_rslt", rslt1, 32'd0);
    check_regs("reset", 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(4);
    issue(F_MFHI, 32'd0, 32'd0);
    issue(F_MFLO, 32'd0, 32'd0);
    check_regs("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

    issue(F_MULT, 32'hFFFF_FFFD, 32'd5);
    idle(36);
    check_regs("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
    idle(36);
    check_regs("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(36);
    check_regs("div_ovf", 32'd0, 32'h8000_0000);

    issue(F_DIVU, 32'h0000_1234, 32'd0);
    issue(F_MFLO, 32'd0, 32'd0);
    issue(F_MFHI, 32'd0, 32'd0);
    check_regs("div_zero", 32'h0000_1234, 32'hFFFF_FFFF);

    issue(F_MTHI, 32'hCAFE_F00D, 32'd0);
    issue(F_MFHI, 32'd0, 32'd0);
    issue(6'h20, 32'h1111_1111, 32'h2222_2222);
    check_regs("mthi_unk", 32'hCAFE_F00D, 32'hFFFF_FFFF);

    issue(F_DIVU, 32'd100, 32'd7);
    idle(9);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_busy1", 32'(busy1), 32'd0);
    chk("rst_mid_busy4", 32'(busy4), 32'd0);
    check_regs("rst_mid", 32'd0, 32'd0);
    mhi = 32'd0;
    mlo = 32'd0;
    busy1_end = -1000;
    busy4_end = -1000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(F_MFLO, 32'd0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(0, 8)];
      issue(f, pick(), pick());
      if (f inside {F_MULT, F_MULTU, F_DIV, F_DIVU}) begin
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 40));
        issue(F_MFHI, 32'd0, 32'd0);
        issue(F_MFLO, 32'd0, 32'd0);
      end
    end
    idle(40);
    check_regs("final", mhi, mlo);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative multiply/divide unit and HI/LO owner beside the combinational ALU in the execute stage. Accepts MULT/MULTU/DIV/DIVU, runs a multi-cycle shift-add / restoring-divide sequence and writes HI/LO. Services MFHI/MFLO/MTHI/MTLO. Drives a stall interlock back to the pipeline while an operation is in flight.

Parameters:
BITS_PER_CYCLE, 1, quotient/product bits retired per iteration; legal values 1, 2 or 4. Iteration count ITERS = 32/BITS_PER_CYCLE.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low (0 = reset)
req_valid  in  1  execute-stage instruction is opcode INST_R with a funct handled here
funct  in  6  R-type funct field
rrs  in  32  rs operand
rrt  in  32  rt operand
stall  out  1  hold the execute-stage instruction this cycle
busy  out  1  sequence in flight (states MUL, DIV or FIX)
rslt  out  32  MFHI/MFLO read data; valid when req_valid && !stall
hi  out  32  current HI register
lo  out  32  current LO register

Behaviour:
- Functs handled: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other funct with req_valid=1: ignored, stall=0, rslt=0.
- Reset (rst=0, async): state=IDLE, hi=lo=0, counter=0, busy=0, stall=0, rslt=0. A reset mid-sequence aborts the operation. No partial HI/LO write.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on accepted MULT/MULTU.
  - IDLE -> DIV on accepted DIV/DIVU.
  - MUL/DIV -> FIX after ITERS iterations.
  - FIX -> IDLE, writing HI/LO at that clock edge.
- busy = (state != IDLE). stall = req_valid && busy && funct is a handled code. It is combinational and never depends on the funct of the in-flight operation.
- Accept is fire-and-forget: in IDLE, MULT/DIV is accepted in one cycle with stall=0, and operands are latched. The pipeline retires it immediately.
- Latency: accept at edge 0; iterations occupy cycles 1..ITERS; FIX occupies cycle ITERS+1; new HI/LO are visible from cycle ITERS+2. With B=1: 34 cycles from accept to readable result.
- In IDLE:
  - MTHI/MTLO write rrs into hi/lo at the edge.
  - MFHI/MFLO drive rslt = hi/lo combinationally.
  - A request in the cycle after FIX sees the new HI/LO.
- Signed ops: operate on magnitudes |rrs|, |rrt| (0x80000000 kept as unsigned 2^31).
  - Multiply: negate the 64-bit product in FIX if the operand signs differ. {HI,LO} = product.
  - Divide: LO = quotient, negated if signs differ. HI = remainder, carrying the dividend's sign.
  - Unsigned ops skip all negation.
- Boundary cases:
  - Divide by zero (any signedness): LO=32'hFFFFFFFF, HI=rrs as latched. The full iteration count still runs, so latency is unchanged.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no trap.
  - MULT accepted while an MTHI write would coincide: impossible, since accept and MT* are both IDLE-only and mutually exclusive per cycle.
- Counter is log2(ITERS)+1 bits, cleared on accept; it has no wrap-around.

Decomposition:
- Shared include: add FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO, FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU beside the existing FUNCT_ defines.
- FSM state encodings are module-local localparams.
- One sub-module, muldiv_step: combinational single iteration of B bits. It covers shift-add for multiply and compare/subtract/shift for restoring divide, with mode select. It is instantiated once and chained B times internally by generate.

Test Plan:
- Reset mid-DIV: accept DIVU 100/7, deassert rst at cycle 10 -> busy=0, hi=lo=0 immediately; a later MFLO returns 0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF (B=1) -> busy for cycles 1..33; MFHI issued at cycle 5 stalls until cycle 34; then MFHI=0xFFFFFFFE and MFLO=0x00000001.
- MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x00001234, with the same latency as a normal divide.
- MTHI 0xCAFEF00D then MFHI back-to-back with no stall -> rslt=0xCAFEF00D. Funct 0x20 with req_valid -> stall=0, rslt=0, hi/lo unchanged. Repeat the MULTU case at B=4 -> readable at cycle 10.
